// File: rtl/group_ctrl_gen.sv
// Group-control waveform generator: dim PWM or slow blink shared by all LEDs in group mode.
// Define GRP_SHADOW_EN to shadow grppwm/grpfreq/dmblnk until each period boundary or sleep exit.
module group_ctrl_gen #(
  parameter int unsigned DIM_DIV   = 4,
  parameter int unsigned BLINK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep,
  input  logic       dmblnk,
  input  logic [7:0] grppwm,
  input  logic [7:0] grpfreq,
  output logic       group_out,
  output logic       period_start
);

  localparam int unsigned MAXDIV = (DIM_DIV > BLINK_DIV) ? DIM_DIV : BLINK_DIV;
  localparam int          PW     = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;

  typedef enum logic {S_DIM = 1'b0, S_BLINK = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt, w_div_m1;
  logic [7:0]      r_sub, w_sub_nxt;
  logic [7:0]      r_phase, w_phase_nxt;
  logic [7:0]      w_duty, w_freq;
  logic            r_sleep_d, r_start, w_start_nxt;
  logic            r_group_out, r_period_start, w_group_nxt;
  logic            w_tick, w_step, w_wrap, w_exit, w_restart;

`ifdef GRP_SHADOW_EN
  logic [7:0] r_duty_eff, r_freq_eff;

  assign w_duty    = r_duty_eff;
  assign w_freq    = r_freq_eff;
  assign w_restart = 1'b0;

  // Shadow values only change at a boundary or when leaving sleep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_eff <= '0;
      r_freq_eff <= '0;
    end else if (!sleep && (w_exit || w_wrap)) begin
      r_duty_eff <= grppwm;
      r_freq_eff <= grpfreq;
    end
  end
`else
  logic r_dmblnk_d;

  assign w_duty    = grppwm;
  assign w_freq    = grpfreq;
  assign w_restart = dmblnk ^ r_dmblnk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dmblnk_d <= 1'b0;
    else     r_dmblnk_d <= dmblnk;
  end
`endif

  assign w_div_m1 = (r_state == S_BLINK) ? PW'(BLINK_DIV - 1) : PW'(DIM_DIV - 1);
  assign w_exit   = ~sleep & r_sleep_d;
  assign w_tick   = (r_presc == w_div_m1);
  assign w_step   = w_tick & ((r_state == S_DIM) | (r_sub == w_freq));
  assign w_wrap   = w_step & (r_phase == 8'hFF);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_sub_nxt   = r_sub;
    w_phase_nxt = r_phase;
    w_start_nxt = 1'b0;
    w_group_nxt = 1'b0;
    if (sleep) begin
      w_presc_nxt = '0;
      w_sub_nxt   = '0;
      w_phase_nxt = '0;
    end else if (w_exit || w_restart) begin
      // Fresh start at phase 0 in the requested mode; pulse follows with the first output.
      w_state_nxt = state_t'(dmblnk);
      w_presc_nxt = '0;
      w_sub_nxt   = '0;
      w_phase_nxt = '0;
      w_start_nxt = 1'b1;
      w_group_nxt = w_exit ? 1'b0 : (r_phase < w_duty);
    end else begin
      w_group_nxt = (r_phase < w_duty);
      w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
      if (w_tick && (r_state == S_BLINK))
        w_sub_nxt = (r_sub == w_freq) ? 8'd0 : r_sub + 8'd1;
      if (w_step)
        w_phase_nxt = r_phase + 8'd1;
      if (w_wrap) begin
        w_start_nxt = 1'b1;
        if (state_t'(dmblnk) != r_state) begin
          w_state_nxt = state_t'(dmblnk);
          w_presc_nxt = '0;
          w_sub_nxt   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_DIM;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc        <= '0;
      r_sub          <= '0;
      r_phase        <= '0;
      r_sleep_d      <= 1'b0;
      r_start        <= 1'b0;
      r_group_out    <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_presc_nxt;
      r_sub          <= w_sub_nxt;
      r_phase        <= w_phase_nxt;
      r_sleep_d      <= sleep;
      r_start        <= w_start_nxt;
      r_group_out    <= w_group_nxt;
      r_period_start <= ~sleep & r_start;
    end
  end

  assign group_out    = r_group_out;
  assign period_start = r_period_start;

endmodule

// File: doc/group_ctrl_gen.md
Name: group_ctrl_gen

Overview:
Generates the shared group-control waveform `group_out` consumed by the LED mode selector for every LED whose LEDOUT field is 11.
- Dim mode (DMBLNK=0): fast PWM of GRPPWM duty, layered on individual PWM.
- Blink mode (DMBLNK=1): slow blink whose period is set by GRPFREQ and whose duty is set by GRPPWM.
- Sits between the register file and the mode selector, next to the individual PWM block.

Parameters:
- DIM_DIV, 4, clk cycles per phase step in dim mode (>=1).
- BLINK_DIV, 16, clk cycles per base tick in blink mode (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- sleep  input  1  oscillator off (MODE1 SLEEP); forces idle.
- dmblnk  input  1  0 = group dim, 1 = group blink (MODE2 DMBLNK).
- grppwm  input  8  group duty, high for grppwm/256 of a period.
- grpfreq  input  8  blink period multiplier (blink mode only).
- group_out  output  1  registered group waveform.
- period_start  output  1  one-cycle pulse on the first cycle of each period.

Behaviour:
- Async reset. On rst=1:
  - group_out=0, period_start=0.
  - All counters 0; state=S_DIM.
  - Effective registers duty_eff=0, freq_eff=0, mode_eff=0.
- Counters:
  - presc: counts 0..DIV-1 and wraps. DIV is DIM_DIV in S_DIM and BLINK_DIV in S_BLINK.
  - tick: single-cycle strobe, asserted when presc==DIV-1.
  - sub, 8 bits, blink only: counts 0..freq_eff and advances on tick.
  - phase, 8 bits: wraps 255->0.
- Phase advance:
  - S_DIM: phase increments on every tick.
  - S_BLINK: phase increments on a tick where sub==freq_eff; sub returns to 0 at that point.
- Resulting periods:
  - Dim period = 256*DIM_DIV cycles.
  - Blink period = 256*(freq_eff+1)*BLINK_DIV cycles.
  - Arithmetic is unsigned; no counter ever saturates.
- Output: group_out <= (phase < duty_eff), i.e. one cycle of latency from phase.
  - duty 0: constant low.
  - duty 255: low for exactly 1 phase step per period.
- Period boundary = the cycle in which phase wraps 255->0. Effects on the next clock edge:
  - period_start pulses for 1 cycle, coincident with the first group_out value of the new period.
  - The effective registers reload from the inputs.
- FSM has two states, S_DIM and S_BLINK.
  - Transitions occur only at a period boundary, when the newly loaded mode_eff differs from the current state.
  - On a transition, presc and sub are cleared so the new mode starts at phase 0 with a full first step.
- Sleep:
  - While sleep=1: presc, sub and phase are held at 0, group_out=0, period_start=0.
  - Cycle sleep falls: the effective registers load from the inputs, state is set from dmblnk, and counting restarts at phase 0.
  - period_start pulses on the first counting cycle.
- Simultaneous events:
  - sleep=1 on a boundary cycle: sleep wins; no reload beyond the sleep-exit load.
  - Input changes mid-period: ignored until the next boundary.
- Reset mid-period: immediate return to reset values; no pulse until the first boundary after release.

Optional Feature:
Macro GRP_SHADOW_EN.
- Defined: grppwm, grpfreq and dmblnk are shadowed and take effect only at a period boundary or on sleep exit, as above. This makes outputs glitch-free.
- Undefined:
  - duty_eff, freq_eff and mode_eff follow the inputs combinationally, every cycle.
  - An edge on dmblnk is detected against a registered copy. It switches state on the next clock, clears presc, sub and phase, and pulses period_start.
  - A grpfreq change takes effect at the next sub comparison. If the new grpfreq is below the current sub, sub runs up to 255 and then wraps.

Test Plan:
1. Dim duty: reset, sleep=0, dmblnk=0, grppwm=64, after the first period_start.
   - Required: group_out high 256 cycles, low 768 cycles, period_start every 1024 cycles.
2. Blink: dmblnk=0->1 with grpfreq=1, grppwm=128.
   - Required: mode switches only at the next period_start.
   - Then group_out high 4096 cycles, low 4096 cycles, period 8192.
3. Duty edges: grppwm=0 -> group_out never high. grppwm=255 in dim mode -> low exactly 4 cycles per 1024.
4. Shadowing (GRP_SHADOW_EN): change grppwm 64->192 at cycle 100 of a dim period.
   - Required: the current period keeps a 256-cycle high time; the next period is high for 768 cycles.
5. Sleep: assert sleep mid-blink.
   - Required: group_out=0 on the next cycle and counters at 0.
   - After deassert: period_start pulses on the first counting cycle, and the waveform restarts at phase 0 with the current inputs.
6. Async reset asserted mid-period, between clock edges.
   - Required: group_out and period_start go 0 immediately; after release the first period_start arrives 1024 cycles later in dim mode.
